cpu_control_fsm: RTL

- Multi-cycle control unit that sequences the RISC-V datapath: instruction ROM, register bank, ALU, data RAM and PC hardware.
- Fetches each instruction and decodes the RV32I subset (R-ALU, I-ALU, LW, SW, BEQ/BNE/BLT/BGE, JAL, LUI).
- Drives per-state write enables, ALU operation and mux selects.
- Stalls on ROM/RAM ready handshakes. Enters a sticky trap on an illegal opcode or a memory timeout.

---
 rtl/cpu_control_fsm.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle RV32I-subset control unit: sequences fetch, decode, execute,
// memory and writeback, stalling on ROM/RAM ready and trapping on faults.
module cpu_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        rom_ready,
  input  logic        ram_ready,
  output logic        rom_read,
  output logic        ir_wren,
  output logic        rb_wren,
  output logic        ram_read,
  output logic        ram_write,
  output logic [3:0]  alu_control,
  output logic        alu_src_imm,
  output logic [1:0]  wb_sel,
  output logic        pc_wren,
  output logic        pc_sel,
  output logic        trap,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_TRAP    = 3'd7;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd15;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  logic [2:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, rd_nz, is_load, is_store;
  logic       unused_instr_bits;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign rd_nz    = (instr[11:7] != 5'd0);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign unused_instr_bits = ^{instr[31], instr[29:15]};

  function automatic logic decode_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R, OP_I, OP_JAL, OP_LUI: decode_legal = 1'b1;
      OP_LOAD, OP_STORE:          decode_legal = (f3 == 3'b010);
      OP_BRANCH:                  decode_legal = (f3 == 3'b000) || (f3 == 3'b001) ||
                                                 (f3 == 3'b100) || (f3 == 3'b101);
      default:                    decode_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_op(input logic alt, input logic [2:0] f3);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic lt);
    case (f3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = !lt;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    rom_read     = 1'b0;
    ir_wren      = 1'b0;
    rb_wren      = 1'b0;
    ram_read     = 1'b0;
    ram_write    = 1'b0;
    alu_control  = ALU_ADD;
    alu_src_imm  = 1'b0;
    wb_sel       = 2'd0;
    pc_wren      = 1'b0;
    pc_sel       = 1'b0;
    trap         = 1'b0;
    case (state)
      S_FETCH: begin
        rom_read = 1'b1;
        if (rom_ready) begin
          ir_wren   = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_cnt == TIMEOUT) begin
          state_nxt = S_TRAP;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      S_DECODE: state_nxt = decode_legal(opcode, funct3) ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        case (opcode)
          OP_R: begin
            alu_control = alu_op(funct7b5, funct3);
            state_nxt   = S_WB;
          end
          OP_I: begin
            // Only SRAI uses bit 30 as an opcode bit; elsewhere it is immediate.
            alu_control = alu_op(funct7b5 && (funct3 == 3'b101), funct3);
            alu_src_imm = 1'b1;
            state_nxt   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_imm = 1'b1;
            state_nxt   = S_MEM;
          end
          OP_BRANCH: begin
            alu_control = funct3[2] ? ALU_SLT : ALU_SUB;
            pc_wren     = 1'b1;
            pc_sel      = branch_taken(funct3, alu_zero, alu_lt);
            state_nxt   = S_FETCH;
          end
          OP_JAL: begin
            pc_wren   = 1'b1;
            pc_sel    = 1'b1;
            rb_wren   = rd_nz;
            wb_sel    = 2'd2;
            state_nxt = S_FETCH;
          end
          OP_LUI: begin
            alu_control = ALU_PASS_B;
            alu_src_imm = 1'b1;
            state_nxt   = S_WB;
          end
          default: state_nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        ram_read  = is_load;
        ram_write = is_store;
        if (ram_ready) begin
          pc_wren   = is_store;
          state_nxt = is_store ? S_FETCH : S_WB;
        end else if (wait_cnt == TIMEOUT) begin
          state_nxt = S_TRAP;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        rb_wren   = rd_nz;
        wb_sel    = is_load ? 2'd1 : 2'd0;
        pc_wren   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_nxt = S_TRAP;
    endcase
    if (state_nxt != state) wait_cnt_nxt = 8'd0;
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

endmodule
